// File: rtl/decoder_8b10b_pkg.sv
// Shared encodings for the 8B/10B link synchronisation controller.
package decoder_8b10b_pkg;

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam int         CNT_W = 8;

endpackage

// File: rtl/decoder_8b10b_comma_detect.sv
// Per-word comma classification and error flag for the sync controller; purely combinational.
module decoder_8b10b_comma_detect
  import decoder_8b10b_pkg::*;
#(
  parameter int         DATA_BYTES = 2,
  parameter logic [7:0] COMMA_CHAR = K28_5
) (
  input  logic                    i_valid,
  input  logic [DATA_BYTES*8-1:0] i_data,
  input  logic [DATA_BYTES-1:0]   i_datak,
  input  logic [DATA_BYTES-1:0]   i_not_in_table,
  input  logic [DATA_BYTES-1:0]   i_disp_err,
  output logic                    o_comma_lane0,
  output logic                    o_comma_misplaced,
  output logic                    o_err
);

  logic [DATA_BYTES-1:0] w_comma;

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign w_comma[gi] = i_valid & i_datak[gi] & (i_data[gi*8 +: 8] == COMMA_CHAR);
    end
  endgenerate

  // A lane-0 comma wins: only a word whose commas all sit in upper lanes asks for a slip.
  assign o_comma_lane0     = w_comma[0];
  assign o_comma_misplaced = ~w_comma[0] & (|(w_comma >> 1));
  assign o_err             = i_valid & (|(i_not_in_table | i_disp_err));

endmodule

// File: rtl/decoder_8b10b_sync_ctrl.sv
// Link sync FSM (LOS/ACQ/SYNC/WAIT) with slip/compliance control and gated data forwarding.
// Define DECODER_SYNC_STATS_EN to add the o_err_total / o_loss_count statistics ports.
module decoder_8b10b_sync_ctrl
  import decoder_8b10b_pkg::*;
#(
  parameter int         DATA_BYTES = 2,
  parameter logic [7:0] COMMA_CHAR = K28_5,
  parameter int         ACQ_COMMAS = 3,
  parameter int         ERR_THRESH = 4,
  parameter int         GOOD_RUN   = 4,
  parameter int         SLIP_WAIT  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [DATA_BYTES*8-1:0] i_data,
  input  logic [DATA_BYTES-1:0]   i_datak,
  input  logic [DATA_BYTES-1:0]   i_not_in_table,
  input  logic [DATA_BYTES-1:0]   i_disp_err,
  output logic                    o_dec_enable,
  output logic                    o_dec_compliance,
  output logic                    o_slip,
  output logic                    o_sync,
  output logic [1:0]              o_state,
  output logic [3:0]              o_err_count,
`ifdef DECODER_SYNC_STATS_EN
  output logic [15:0]             o_err_total,
  output logic [7:0]              o_loss_count,
`endif
  output logic                    o_valid,
  output logic [DATA_BYTES*8-1:0] o_data,
  output logic [DATA_BYTES-1:0]   o_datak
);

  localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(ACQ_COMMAS - 1);
  localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(GOOD_RUN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SLIP_WAIT - 1);
  localparam logic [3:0]       ERR_LIM   = 4'(ERR_THRESH);

  logic w_comma0, w_misplaced, w_err, w_err_sync;
  logic [3:0] w_err_inc;

  state_t           r_state, r_state_next;
  logic [CNT_W-1:0] r_acq, r_acq_next, r_good, r_good_next, r_wait, r_wait_next;
  logic [3:0]       r_err, r_err_next;
  logic             r_slip, r_slip_next, r_comp, r_comp_next;
  logic             r_dec_enable, r_sync, r_valid;
  logic [DATA_BYTES*8-1:0] r_data;
  logic [DATA_BYTES-1:0]   r_datak;

  decoder_8b10b_comma_detect #(
    .DATA_BYTES(DATA_BYTES),
    .COMMA_CHAR(COMMA_CHAR)
  ) u_comma (
    .i_valid          (i_valid),
    .i_data           (i_data),
    .i_datak          (i_datak),
    .i_not_in_table   (i_not_in_table),
    .i_disp_err       (i_disp_err),
    .o_comma_lane0    (w_comma0),
    .o_comma_misplaced(w_misplaced),
    .o_err            (w_err)
  );

  // Once aligned, a comma in the wrong lane is treated as corruption rather than a slip request.
  assign w_err_sync = w_err | w_misplaced;
  assign w_err_inc  = (r_err == 4'hF) ? r_err : r_err + 4'd1;

  always_comb begin
    r_state_next = r_state;
    r_acq_next   = r_acq;
    r_good_next  = r_good;
    r_err_next   = r_err;
    r_wait_next  = r_wait;
    r_slip_next  = 1'b0;
    r_comp_next  = 1'b0;
    case (r_state)
      ST_LOS: begin
        if (w_comma0 && !w_err) begin
          r_state_next = ST_ACQ;
          r_acq_next   = CNT_W'(1);
        end else if (w_misplaced) begin
          r_state_next = ST_WAIT;
          r_slip_next  = 1'b1;
          r_wait_next  = '0;
        end
      end
      ST_ACQ: begin
        if (w_err) begin
          r_state_next = ST_LOS;
          r_comp_next  = 1'b1;
        end else if (w_misplaced) begin
          r_state_next = ST_WAIT;
          r_slip_next  = 1'b1;
          r_wait_next  = '0;
        end else if (w_comma0) begin
          if (r_acq >= ACQ_LAST) begin
            r_state_next = ST_SYNC;
            r_err_next   = '0;
            r_good_next  = '0;
          end else begin
            r_acq_next = r_acq + CNT_W'(1);
          end
        end
      end
      ST_SYNC: begin
        if (w_err_sync) begin
          r_good_next = '0;
          r_err_next  = w_err_inc;
          if (w_err_inc >= ERR_LIM) begin
            r_state_next = ST_LOS;
            r_comp_next  = 1'b1;
          end
        end else if (i_valid) begin
          if (r_good >= GOOD_LAST) begin
            r_good_next = '0;
            if (r_err != 4'd0) r_err_next = r_err - 4'd1;
          end else begin
            r_good_next = r_good + CNT_W'(1);
          end
        end
      end
      default: begin
        if (r_wait >= WAIT_LAST) r_state_next = ST_LOS;
        else r_wait_next = r_wait + CNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_LOS;
      r_acq        <= '0;
      r_good       <= '0;
      r_err        <= '0;
      r_wait       <= '0;
      r_slip       <= 1'b0;
      r_comp       <= 1'b0;
      r_dec_enable <= 1'b1;
      r_sync       <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_datak      <= '0;
    end else begin
      r_state      <= r_state_next;
      r_acq        <= r_acq_next;
      r_good       <= r_good_next;
      r_err        <= r_err_next;
      r_wait       <= r_wait_next;
      r_slip       <= r_slip_next;
      r_comp       <= r_comp_next;
      r_dec_enable <= (r_state_next != ST_WAIT);
      r_sync       <= (r_state_next == ST_SYNC);
      // The word that knocks the link out of SYNC is dropped, not forwarded.
      r_valid      <= i_valid && (r_state == ST_SYNC) && (r_state_next == ST_SYNC);
      r_data       <= i_data;
      r_datak      <= i_datak;
    end
  end

`ifdef DECODER_SYNC_STATS_EN
  logic [15:0] r_err_total;
  logic [7:0]  r_loss_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_total  <= '0;
      r_loss_count <= '0;
    end else begin
      if (r_state == ST_SYNC && w_err_sync && r_err_total != 16'hFFFF)
        r_err_total <= r_err_total + 16'd1;
      if (r_state == ST_SYNC && r_state_next == ST_LOS && r_loss_count != 8'hFF)
        r_loss_count <= r_loss_count + 8'd1;
    end
  end

  assign o_err_total  = r_err_total;
  assign o_loss_count = r_loss_count;
`endif

  assign o_dec_enable     = r_dec_enable;
  assign o_dec_compliance = r_comp;
  assign o_slip           = r_slip;
  assign o_sync           = r_sync;
  assign o_state          = r_state;
  assign o_err_count      = r_err;
  assign o_valid          = r_valid;
  assign o_data           = r_data;
  assign o_datak          = r_datak;

endmodule
